// File: rtl/id_stage.sv
// id_stage: RV32I decode with operand forwarding, load-use interlock and an
// ID/EX pipeline register with valid/ready handshakes on both sides.
// Optional feature macro: ID_JAL_REDIRECT_EN (JAL redirect issued from ID).
// Encoding notes:
//   - an instruction word whose opcode is 7'b0000000 is the Flushed slot that
//     fetch inserts after a mispredict; it travels to EX as a NOP with
//     out_if_br set.
//   - out_rd always carries inst[11:7]; out_rd_e says whether it is written.
module id_stage #(
  parameter int XLEN      = 32,
  parameter int FWD_PORTS = 2,
  parameter int REG_AW    = 5,
  localparam int ALUOP_W  = 5,
  localparam int ALUSEL_W = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [XLEN-1:0]               pc,
  input  logic [XLEN-1:0]               npc,
  input  logic [XLEN-1:0]               pred_i,
  input  logic [31:0]                   inst,
  input  logic                          flush,
  output logic                          re1,
  output logic                          re2,
  output logic [REG_AW-1:0]             raddr1,
  output logic [REG_AW-1:0]             raddr2,
  input  logic [XLEN-1:0]               rdata1,
  input  logic [XLEN-1:0]               rdata2,
  input  logic [FWD_PORTS-1:0]          fwd_we,
  input  logic [FWD_PORTS*REG_AW-1:0]   fwd_waddr,
  input  logic [FWD_PORTS*XLEN-1:0]     fwd_wdata,
  input  logic [FWD_PORTS-1:0]          fwd_pend,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_pc,
  output logic [XLEN-1:0]               out_npc,
  output logic [XLEN-1:0]               out_pred,
  output logic [ALUOP_W-1:0]            out_aluop,
  output logic [ALUSEL_W-1:0]           out_alusel,
  output logic [XLEN-1:0]               out_reg1,
  output logic [XLEN-1:0]               out_reg2,
  output logic [XLEN-1:0]               out_imm,
  output logic [XLEN-1:0]               out_jmp_addr,
  output logic [REG_AW-1:0]             out_rd,
  output logic                          out_rd_e,
  output logic [4:0]                    out_mem_length,
  output logic                          out_if_br
`ifdef ID_JAL_REDIRECT_EN
  ,
  output logic                          redirect_valid,
  output logic [XLEN-1:0]               redirect_addr
`endif
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FLUSH  = 7'b0000000;

  localparam logic [ALUOP_W-1:0] OP_NOP = 5'd0,  OP_ADD  = 5'd1,  OP_SUB  = 5'd2,
                                 OP_SLL = 5'd3,  OP_SLT  = 5'd4,  OP_SLTU = 5'd5,
                                 OP_XOR = 5'd6,  OP_SRL  = 5'd7,  OP_SRA  = 5'd8,
                                 OP_OR  = 5'd9,  OP_AND  = 5'd10, OP_BEQ  = 5'd11,
                                 OP_BNE = 5'd12, OP_BLT  = 5'd13, OP_BGE  = 5'd14,
                                 OP_BLTU = 5'd15, OP_BGEU = 5'd16, OP_JAL = 5'd17,
                                 OP_JALR = 5'd18, OP_LOAD = 5'd19, OP_STORE = 5'd20;

  localparam logic [ALUSEL_W-1:0] SEL_NOP = 3'd0, SEL_ALU = 3'd1, SEL_SHIFT = 3'd2,
                                  SEL_JUMP = 3'd3, SEL_BRANCH = 3'd4,
                                  SEL_LOAD = 3'd5, SEL_STORE = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     npc;
    logic [XLEN-1:0]     pred;
    logic [XLEN-1:0]     reg1;
    logic [XLEN-1:0]     reg2;
    logic [XLEN-1:0]     imm;
    logic [XLEN-1:0]     jmp;
    logic [ALUOP_W-1:0]  aluop;
    logic [ALUSEL_W-1:0] alusel;
    logic [REG_AW-1:0]   rd;
    logic                rd_e;
    logic [4:0]          mem_length;
    logic                if_br;
  } idex_t;

  idex_t idex_d, idex_q;
  logic  valid_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, shamt, pc4;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign imm_i  = XLEN'($signed(inst[31:20]));
  assign imm_s  = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b  = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_j  = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
  assign imm_u  = XLEN'($signed({inst[31:12], 12'b0}));
  assign shamt  = XLEN'(inst[24:20]);
  assign pc4    = pc + XLEN'(4);

  assign raddr1 = REG_AW'(inst[19:15]);
  assign raddr2 = REG_AW'(inst[24:20]);

  logic                re1_c, re2_c, rd_e_c, if_br_c, nop_c;
  logic                is_jal, is_jalr, is_br;
  logic [XLEN-1:0]     imm_c;
  logic [ALUOP_W-1:0]  aluop_c;
  logic [ALUSEL_W-1:0] alusel_c;
  logic [4:0]          mem_c;

  // Opcode/funct decode; any undefined encoding collapses to a NOP at the end.
  always_comb begin
    re1_c = 1'b0; re2_c = 1'b0; rd_e_c = 1'b0; if_br_c = 1'b0; nop_c = 1'b0;
    is_jal = 1'b0; is_jalr = 1'b0; is_br = 1'b0;
    imm_c = '0; aluop_c = OP_NOP; alusel_c = SEL_NOP; mem_c = '0;
    case (opcode)
      OPC_LUI:   begin imm_c = imm_u; aluop_c = OP_ADD; alusel_c = SEL_ALU; rd_e_c = 1'b1; end
      OPC_AUIPC: begin imm_c = pc + imm_u; aluop_c = OP_ADD; alusel_c = SEL_ALU; rd_e_c = 1'b1; end
      OPC_JAL:   begin imm_c = pc4; aluop_c = OP_JAL; alusel_c = SEL_JUMP; rd_e_c = 1'b1; is_jal = 1'b1; end
      OPC_JALR: begin
        re1_c = 1'b1; imm_c = pc4; aluop_c = OP_JALR; alusel_c = SEL_JUMP; rd_e_c = 1'b1; is_jalr = 1'b1;
        if (funct3 != 3'b000) nop_c = 1'b1;
      end
      OPC_BRANCH: begin
        re1_c = 1'b1; re2_c = 1'b1; imm_c = imm_b; alusel_c = SEL_BRANCH; is_br = 1'b1;
        case (funct3)
          3'b000: aluop_c = OP_BEQ;
          3'b001: aluop_c = OP_BNE;
          3'b100: aluop_c = OP_BLT;
          3'b101: aluop_c = OP_BGE;
          3'b110: aluop_c = OP_BLTU;
          3'b111: aluop_c = OP_BGEU;
          default: nop_c = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        re1_c = 1'b1; imm_c = imm_i; aluop_c = OP_LOAD; alusel_c = SEL_LOAD; rd_e_c = 1'b1;
        case (funct3)
          3'b000: mem_c = 5'b00001;
          3'b001: mem_c = 5'b00010;
          3'b010: mem_c = 5'b00100;
          3'b100: mem_c = 5'b01001;
          3'b101: mem_c = 5'b01010;
          default: nop_c = 1'b1;
        endcase
      end
      OPC_STORE: begin
        re1_c = 1'b1; re2_c = 1'b1; imm_c = imm_s; aluop_c = OP_STORE; alusel_c = SEL_STORE;
        case (funct3)
          3'b000: mem_c = 5'b10001;
          3'b001: mem_c = 5'b10010;
          3'b010: mem_c = 5'b10100;
          default: nop_c = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        re1_c = 1'b1; imm_c = imm_i; alusel_c = SEL_ALU; rd_e_c = 1'b1;
        case (funct3)
          3'b000: aluop_c = OP_ADD;
          3'b010: aluop_c = OP_SLT;
          3'b011: aluop_c = OP_SLTU;
          3'b100: aluop_c = OP_XOR;
          3'b110: aluop_c = OP_OR;
          3'b111: aluop_c = OP_AND;
          3'b001: begin
            imm_c = shamt; alusel_c = SEL_SHIFT; aluop_c = OP_SLL;
            if (funct7 != 7'b0000000) nop_c = 1'b1;
          end
          default: begin
            imm_c = shamt; alusel_c = SEL_SHIFT;
            if (funct7 == 7'b0000000)      aluop_c = OP_SRL;
            else if (funct7 == 7'b0100000) aluop_c = OP_SRA;
            else                           nop_c = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        re1_c = 1'b1; re2_c = 1'b1; alusel_c = SEL_ALU; rd_e_c = 1'b1;
        if (funct7 != 7'b0000000 && !(funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
          nop_c = 1'b1;
        case (funct3)
          3'b000: aluop_c = funct7[5] ? OP_SUB : OP_ADD;
          3'b001: begin aluop_c = OP_SLL; alusel_c = SEL_SHIFT; end
          3'b010: aluop_c = OP_SLT;
          3'b011: aluop_c = OP_SLTU;
          3'b100: aluop_c = OP_XOR;
          3'b101: begin aluop_c = funct7[5] ? OP_SRA : OP_SRL; alusel_c = SEL_SHIFT; end
          3'b110: aluop_c = OP_OR;
          default: aluop_c = OP_AND;
        endcase
      end
      OPC_FLUSH: if_br_c = 1'b1;
      default: nop_c = 1'b1;
    endcase
    if (nop_c) begin
      re1_c = 1'b0; re2_c = 1'b0; rd_e_c = 1'b0; imm_c = '0;
      aluop_c = OP_NOP; alusel_c = SEL_NOP; mem_c = '0;
      is_jal = 1'b0; is_jalr = 1'b0; is_br = 1'b0;
    end
  end

  assign re1 = re1_c;
  assign re2 = re2_c;

  logic [XLEN-1:0] rs1_v, rs2_v;
  logic            pend1, pend2;

  // Operand resolution: lowest matching source index wins, x0 reads as zero.
  // Walking from the oldest source down lets younger matches overwrite.
  always_comb begin
    rs1_v = rdata1; pend1 = 1'b0;
    rs2_v = rdata2; pend2 = 1'b0;
    for (int i = FWD_PORTS - 1; i >= 0; i--) begin
      if (fwd_we[i] && fwd_waddr[i*REG_AW +: REG_AW] == raddr1) begin
        rs1_v = fwd_wdata[i*XLEN +: XLEN];
        pend1 = fwd_pend[i];
      end
      if (fwd_we[i] && fwd_waddr[i*REG_AW +: REG_AW] == raddr2) begin
        rs2_v = fwd_wdata[i*XLEN +: XLEN];
        pend2 = fwd_pend[i];
      end
    end
    if (raddr1 == '0) begin rs1_v = '0; pend1 = 1'b0; end
    if (raddr2 == '0) begin rs2_v = '0; pend2 = 1'b0; end
  end

  logic hazard, ld;
  assign hazard   = in_valid && ((re1_c && pend1) || (re2_c && pend2));
  assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
  assign ld       = in_valid && in_ready;

  // Next ID/EX contents, captured only on ld.
  always_comb begin
    idex_d            = '0;
    idex_d.pc         = pc;
    idex_d.npc        = npc;
    idex_d.pred       = pred_i;
    idex_d.reg1       = re1_c ? rs1_v : '0;
    idex_d.reg2       = re2_c ? rs2_v : imm_c;
    idex_d.imm        = imm_c;
    idex_d.aluop      = aluop_c;
    idex_d.alusel     = alusel_c;
    idex_d.rd         = REG_AW'(inst[11:7]);
    idex_d.rd_e       = rd_e_c;
    idex_d.mem_length = mem_c;
    idex_d.if_br      = if_br_c;
    if (is_jal)       idex_d.jmp = pc + imm_j;
    else if (is_jalr) idex_d.jmp = (rs1_v + imm_i) & ~XLEN'(1);
    else if (is_br)   idex_d.jmp = pc + imm_b;
  end

  // ID/EX register: flush kills, ld captures, a drained slot becomes a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      idex_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (ld) begin
      valid_q <= 1'b1;
      idex_q  <= idex_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid      = valid_q;
  assign out_pc         = idex_q.pc;
  assign out_npc        = idex_q.npc;
  assign out_pred       = idex_q.pred;
  assign out_aluop      = idex_q.aluop;
  assign out_alusel     = idex_q.alusel;
  assign out_reg1       = idex_q.reg1;
  assign out_reg2       = idex_q.reg2;
  assign out_imm        = idex_q.imm;
  assign out_jmp_addr   = idex_q.jmp;
  assign out_rd         = idex_q.rd;
  assign out_rd_e       = idex_q.rd_e;
  assign out_mem_length = idex_q.mem_length;
  assign out_if_br      = idex_q.if_br;

`ifdef ID_JAL_REDIRECT_EN
  logic redir_q;

  // One-cycle redirect pulse alongside a freshly loaded JAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) redir_q <= 1'b0;
    else     redir_q <= ld && is_jal;
  end

  assign redirect_valid = redir_q;
  assign redirect_addr  = idex_q.jmp;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed instructions, expected ID/EX contents queued on
// acceptance and checked by a monitor whenever EX takes an instruction.
module tb_id_stage;
  localparam int XLEN = 32, FP = 2, AW = 5;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic in_ready, re1, re2, out_valid, out_rd_e, out_if_br;
  logic [31:0] pc = '0, npc = '0, pred_i = '0, inst = '0;
  logic [31:0] rdata1 = 32'h0BAD0BAD, rdata2 = 32'h0C0FFEE0;
  logic [AW-1:0] raddr1, raddr2, out_rd;
  logic [FP-1:0] fwd_we = '0, fwd_pend = '0;
  logic [FP*AW-1:0] fwd_waddr = '0;
  logic [FP*XLEN-1:0] fwd_wdata = '0;
  logic [31:0] out_pc, out_npc, out_pred, out_reg1, out_reg2, out_imm, out_jmp_addr;
  logic [4:0] out_aluop, out_mem_length;
  logic [2:0] out_alusel;
`ifdef ID_JAL_REDIRECT_EN
  logic redirect_valid;
  logic [31:0] redirect_addr;
`endif

  id_stage #(.XLEN(XLEN), .FWD_PORTS(FP), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .npc(npc), .pred_i(pred_i), .inst(inst), .flush(flush),
    .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_pend(fwd_pend),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_npc(out_npc), .out_pred(out_pred),
    .out_aluop(out_aluop), .out_alusel(out_alusel),
    .out_reg1(out_reg1), .out_reg2(out_reg2), .out_imm(out_imm), .out_jmp_addr(out_jmp_addr),
    .out_rd(out_rd), .out_rd_e(out_rd_e), .out_mem_length(out_mem_length), .out_if_br(out_if_br)
`ifdef ID_JAL_REDIRECT_EN
    , .redirect_valid(redirect_valid), .redirect_addr(redirect_addr)
`endif
  );

  always #5 clk = ~clk;

  // aluop / alusel encodings of the design
  localparam logic [4:0] NOP = 0, ADD = 1, SRA = 8, XOR = 6, BEQ = 11, JAL = 17, JALR = 18, LD = 19, ST = 20;
  localparam logic [2:0] S_NOP = 0, S_ALU = 1, S_SHIFT = 2, S_JUMP = 3, S_BR = 4, S_LD = 5, S_ST = 6;

  typedef struct {
    string       tag;
    logic [31:0] pc, reg1, reg2, imm, jmp;
    logic [4:0]  rd;
    logic        rd_e;
    logic [4:0]  aluop;
    logic [2:0]  alusel;
    logic [4:0]  mem;
    logic        if_br;
  } exp_t;

  exp_t sb_q[$];
  int pass_cnt = 0, total_cnt = 0;

  function automatic exp_t mk(string t, logic [31:0] p, logic [31:0] r1, logic [31:0] r2,
                              logic [31:0] im, logic [31:0] j, logic [4:0] rd, logic rde,
                              logic [4:0] op, logic [2:0] sel, logic [4:0] mem, logic ib);
    exp_t e;
    e.tag = t; e.pc = p; e.reg1 = r1; e.reg2 = r2; e.imm = im; e.jmp = j; e.rd = rd;
    e.rd_e = rde; e.aluop = op; e.alusel = sel; e.mem = mem; e.if_br = ib;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    total_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, want);
  endtask

  // Monitor: every instruction EX takes must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_output: got pc %h want none", out_pc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.tag, ".pc"},     out_pc,         e.pc);
        check({e.tag, ".npc"},    out_npc,        e.pc + 32'd4);
        check({e.tag, ".pred"},   out_pred,       e.pc + 32'd8);
        check({e.tag, ".reg1"},   out_reg1,       e.reg1);
        check({e.tag, ".reg2"},   out_reg2,       e.reg2);
        check({e.tag, ".imm"},    out_imm,        e.imm);
        check({e.tag, ".jmp"},    out_jmp_addr,   e.jmp);
        check({e.tag, ".rd"},     32'(out_rd),    32'(e.rd));
        check({e.tag, ".rd_e"},   32'(out_rd_e),  32'(e.rd_e));
        check({e.tag, ".aluop"},  32'(out_aluop), 32'(e.aluop));
        check({e.tag, ".alusel"}, 32'(out_alusel), 32'(e.alusel));
        check({e.tag, ".mem"},    32'(out_mem_length), 32'(e.mem));
        check({e.tag, ".if_br"},  32'(out_if_br), 32'(e.if_br));
      end
    end
  end

  task automatic drive(input logic [31:0] p, input logic [31:0] ins);
    pc = p; npc = p + 32'd4; pred_i = p + 32'd8; inst = ins; in_valid = 1'b1;
  endtask

  task automatic set_fwd(input int i, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic pend);
    fwd_we[i] = we; fwd_waddr[i*AW +: AW] = a; fwd_wdata[i*XLEN +: XLEN] = d; fwd_pend[i] = pend;
  endtask

  task automatic clr_fwd();
    fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; fwd_pend = '0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the instruction is taken.
  task automatic send(input logic [31:0] p, input logic [31:0] ins, input exp_t e);
    bit ok = 1'b0;
    drive(p, ins);
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (ok) sb_q.push_back(e);
    check({"accept.", e.tag}, 32'(ok), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.out_pc",    out_pc, 0);
    check("rst.out_imm",   out_imm, 0);
    check("rst.in_ready",  32'(in_ready), 1);
`ifdef ID_JAL_REDIRECT_EN
    check("rst.redirect_valid", 32'(redirect_valid), 0);
`endif
    @(posedge clk); #1; rst = 1'b0;
    idle(1);

    // Back-to-back ADDI / ADD with EX forwarding of x1
    send(32'h10, 32'h00500093, mk("addi_x1", 32'h10, 0, 5, 5, 0, 1, 1, ADD, S_ALU, 0, 0));
    set_fwd(0, 1, 5'd1, 32'd5, 0);
    send(32'h14, 32'h00108133, mk("add_fwd", 32'h14, 5, 5, 0, 0, 2, 1, ADD, S_ALU, 0, 0));
    clr_fwd();

    // Two sources write x3: youngest wins; x0 stays zero
    set_fwd(0, 1, 5'd3, 32'hA, 0); set_fwd(1, 1, 5'd3, 32'hB, 0);
    send(32'h18, 32'h00018333, mk("prio_x3", 32'h18, 32'hA, 0, 0, 0, 6, 1, ADD, S_ALU, 0, 0));
    set_fwd(0, 1, 5'd0, 32'hFF, 0); set_fwd(1, 1, 5'd3, 32'hB, 0);
    send(32'h1C, 32'h003003B3, mk("x0_fwd", 32'h1C, 0, 32'hB, 0, 0, 7, 1, ADD, S_ALU, 0, 0));
    clr_fwd();

    // Load-use: LW x4 then ADD x5,x4,x4 with pend for one cycle
    send(32'h20, 32'h00802203, mk("lw_x4", 32'h20, 0, 8, 8, 0, 4, 1, LD, S_LD, 5'b00100, 0));
    set_fwd(0, 1, 5'd4, 32'h1234, 1);
    drive(32'h24, 32'h004202B3);
    @(negedge clk);
    check("hazard.in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    fwd_pend[0] = 1'b0;
    @(negedge clk);
    check("hazard.bubble", 32'(out_valid), 0);
    check("hazard.release", 32'(in_ready), 1);
    sb_q.push_back(mk("add_after_ld", 32'h24, 32'h1234, 32'h1234, 0, 0, 5, 1, ADD, S_ALU, 0, 0));
    @(posedge clk); #1;
    in_valid = 1'b0; clr_fwd();

    // Decode coverage
    set_fwd(0, 1, 5'd2, 32'h203, 0);
    send(32'h200, 32'h004100E7, mk("jalr", 32'h200, 32'h203, 32'h204, 32'h204, 32'h206, 1, 1, JALR, S_JUMP, 0, 0));
    clr_fwd();
    send(32'h300, 32'hFE208CE3, mk("beq", 32'h300, 32'h0BAD0BAD, 32'h0C0FFEE0, 32'hFFFFFFF8, 32'h2F8, 25, 0, BEQ, S_BR, 0, 0));
    send(32'h304, 32'h4040D193, mk("srai", 32'h304, 32'h0BAD0BAD, 4, 4, 0, 3, 1, SRA, S_SHIFT, 0, 0));
    send(32'h308, 32'h0020A623, mk("sw", 32'h308, 32'h0BAD0BAD, 32'h0C0FFEE0, 12, 0, 12, 0, ST, S_ST, 5'b10100, 0));
    send(32'h30C, 32'h12345537, mk("lui", 32'h30C, 0, 32'h12345000, 32'h12345000, 0, 10, 1, ADD, S_ALU, 0, 0));
    send(32'h310, 32'hFFFFFFFF, mk("unknown", 32'h310, 0, 0, 0, 0, 31, 0, NOP, S_NOP, 0, 0));
    send(32'h314, 32'h02108133, mk("bad_f7", 32'h314, 0, 0, 0, 0, 2, 0, NOP, S_NOP, 0, 0));
    send(32'h400, 32'h00000000, mk("flushed", 32'h400, 0, 0, 0, 0, 0, 0, NOP, S_NOP, 0, 1));

    // JAL at 0x100, offset +0x20
    send(32'h100, 32'h020000EF, mk("jal", 32'h100, 0, 32'h104, 32'h104, 32'h120, 1, 1, JAL, S_JUMP, 0, 0));
`ifdef ID_JAL_REDIRECT_EN
    @(negedge clk);
    check("redir.valid", 32'(redirect_valid), 1);
    check("redir.addr", redirect_addr, 32'h120);
    @(negedge clk);
    check("redir.pulse", 32'(redirect_valid), 0);
`endif
    idle(2);

    // Backpressure for 3 cycles with flush in cycle 2
    out_ready = 1'b0;
    send(32'h500, 32'hFFF0C413, mk("xori_killed", 32'h500, 32'h0BAD0BAD, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 8, 1, XOR, S_ALU, 0, 0));
    drive(32'h504, 32'h00100493);
    @(negedge clk);
    check("bp.valid", 32'(out_valid), 1);
    check("bp.in_ready", 32'(in_ready), 0);
    check("bp.reg1", out_reg1, 32'h0BAD0BAD);
    check("bp.pc", out_pc, 32'h500);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("bp_flush.in_ready", 32'(in_ready), 0);
    check("bp_flush.imm", out_imm, 32'hFFFFFFFF);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush.out_valid", 32'(out_valid), 0);
    check("flush.in_ready", 32'(in_ready), 1);
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    sb_q.push_back(mk("addi_x9", 32'h504, 0, 1, 1, 0, 9, 1, ADD, S_ALU, 0, 0));
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    idle(2);

    // Reset mid-stall
    out_ready = 1'b0;
    send(32'h600, 32'h00100593, mk("addi_x11_killed", 32'h600, 0, 1, 1, 0, 11, 1, ADD, S_ALU, 0, 0));
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst.out_valid", 32'(out_valid), 0);
    check("arst.out_pc", out_pc, 0);
    check("arst.out_imm", out_imm, 0);
    check("arst.out_rd", 32'(out_rd), 0);
    check("arst.out_rd_e", 32'(out_rd_e), 0);
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    send(32'h700, 32'h00500093, mk("addi_post_rst", 32'h700, 0, 5, 5, 0, 1, 1, ADD, S_ALU, 0, 0));
    idle(3);

    check("scoreboard.drained", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
